// File: rtl/modbus_frame_sender_pkg.sv
// Shared constants, state encoding and inter-frame gap formula for the Modbus RTU sender.
// MODBUS_AUTO_CRC_EN adds the CRC_LO/CRC_HI states that append the CRC16 bytes.
package modbus_frame_sender_pkg;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

`ifdef MODBUS_AUTO_CRC_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    WAIT   = 3'd2,
    CRC_LO = 3'd3,
    CRC_HI = 3'd4,
    GAP    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    GAP  = 3'd5
  } state_t;
`endif

  // 3.5 characters of 11 bits = 38.5 bit times; 64-bit math keeps CLK_FREQ*385 in range.
  function automatic int gap_cycles(input int clk_freq, input int baud_rate);
    longint num;
    longint den;
    num = longint'(clk_freq) * 385;
    den = longint'(baud_rate) * 10;
    return int'(num / den);
  endfunction

endpackage

// File: rtl/modbus_frame_sender_crc.sv
// Modbus CRC16 single-byte update (reflected poly A001, LSB first), purely combinational.
// Shared with the receive path.
module modbus_crc_byte
  import modbus_frame_sender_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/modbus_frame_sender.sv
// Modbus RTU frame transmitter: buffered payload, uart_byte_tx start/done handshake, 3.5-char gap.
// Define MODBUS_AUTO_CRC_EN to append the CRC16 low/high bytes after the payload.
module modbus_frame_sender
  import modbus_frame_sender_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_LEN   = 16,
  parameter int AW        = 4,
  parameter int LW        = 5
) (
  input  logic          sys_clk,
  input  logic          reset_n,
  input  logic          buf_wr_en,
  input  logic [AW-1:0] buf_wr_addr,
  input  logic [7:0]    buf_wr_data,
  input  logic [LW-1:0] frame_len,
  input  logic          frame_start,
  output logic          busy,
  output logic          frame_done,
  output logic          err_len,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_done,
  output logic [15:0]   crc_out
);

  localparam int GAP_CYCLES = gap_cycles(CLK_FREQ, BAUD_RATE);
  localparam int GW         = $clog2(GAP_CYCLES + 1);

`ifdef MODBUS_AUTO_CRC_EN
  localparam state_t AFTER_PAYLOAD = CRC_LO;
`else
  localparam state_t AFTER_PAYLOAD = GAP;
`endif

  // Handshake: tx_start is a one-cycle pulse with tx_data valid; tx_data holds until the
  // matching one-cycle tx_done, which is only honoured while a byte is outstanding.
  state_t        state, state_next;
  logic [7:0]    mem [MAX_LEN];
  logic [AW-1:0] idx;
  logic [LW-1:0] len;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    cur_byte;
  logic [15:0]   crc_next;
  logic          len_ok, last_byte, gap_end;
`ifdef MODBUS_AUTO_CRC_EN
  logic          crc_sent;
`endif

  assign cur_byte  = mem[idx];
  assign len_ok    = (frame_len != '0) && (32'(frame_len) <= MAX_LEN);
  assign last_byte = (32'(idx) + 32'd1) >= 32'(len);
  assign gap_end   = (32'(gap_cnt) == GAP_CYCLES - 1);

  modbus_crc_byte u_crc (
    .crc_in  (crc_out),
    .data    (cur_byte),
    .crc_out (crc_next)
  );

  always_ff @(posedge sys_clk) begin
    if (buf_wr_en && !busy && (32'(buf_wr_addr) < MAX_LEN)) begin
      mem[buf_wr_addr] <= buf_wr_data;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (frame_start && len_ok) state_next = SEND;
      SEND: state_next = WAIT;
      WAIT: if (tx_done) state_next = last_byte ? AFTER_PAYLOAD : SEND;
`ifdef MODBUS_AUTO_CRC_EN
      CRC_LO: if (crc_sent && tx_done) state_next = CRC_HI;
      CRC_HI: if (crc_sent && tx_done) state_next = GAP;
`endif
      GAP:  if (gap_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      crc_out    <= CRC_INIT;
      idx        <= '0;
      len        <= '0;
      gap_cnt    <= '0;
`ifdef MODBUS_AUTO_CRC_EN
      crc_sent   <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      tx_start   <= 1'b0;
      case (state)
        IDLE: if (frame_start) begin
          if (len_ok) begin
            len     <= frame_len;
            idx     <= '0;
            crc_out <= CRC_INIT;
            busy    <= 1'b1;
          end else begin
            err_len <= 1'b1;
          end
        end
        SEND: begin
          tx_start <= 1'b1;
          tx_data  <= cur_byte;
          crc_out  <= crc_next;
        end
        WAIT: if (tx_done) begin
          if (!last_byte) idx <= idx + 1'b1;
          gap_cnt <= '0;
`ifdef MODBUS_AUTO_CRC_EN
          crc_sent <= 1'b0;
`endif
        end
`ifdef MODBUS_AUTO_CRC_EN
        CRC_LO, CRC_HI: begin
          if (!crc_sent) begin
            tx_start <= 1'b1;
            tx_data  <= (state == CRC_LO) ? crc_out[7:0] : crc_out[15:8];
            crc_sent <= 1'b1;
          end else if (tx_done) begin
            crc_sent <= 1'b0;
          end
        end
`endif
        GAP: begin
          // frame_done lands on the last gap cycle, while busy is still high.
          frame_done <= (32'(gap_cnt) == GAP_CYCLES - 2);
          if (gap_end) begin
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_frame_sender.sv
// Directed bench for modbus_frame_sender: frame table plus hand sequences for errors,
// gap behaviour and mid-frame reset. Works with or without MODBUS_AUTO_CRC_EN.
module tb_modbus_frame_sender;

  localparam int UART_CYC = 20;
  localparam int GAP_EXP  = 16710;
`ifdef MODBUS_AUTO_CRC_EN
  localparam int CRC_BYTES = 2;
`else
  localparam int CRC_BYTES = 0;
`endif

  typedef struct {
    int          len;
    logic [7:0]  data [16];
    logic [15:0] exp_crc;
    bit          full_gap;
    bit          chk_space;
  } frame_vec_t;

  logic        sys_clk, reset_n;
  logic        buf_wr_en;
  logic [3:0]  buf_wr_addr;
  logic [7:0]  buf_wr_data;
  logic [4:0]  frame_len;
  logic        frame_start;
  logic        busy, frame_done, err_len, tx_start, tx_done;
  logic [7:0]  tx_data;
  logic [15:0] crc_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, fs_cyc = 0;
  int start_cnt = 0, done_cnt = 0, fd_cnt = 0, err_cnt = 0;
  int last_done_cyc = 0, fd_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         start_cyc_q[$];
  frame_vec_t vecs [3];
  frame_vec_t vb, vc;

  modbus_frame_sender dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .frame_len   (frame_len),
    .frame_start (frame_start),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_len     (err_len),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .crc_out     (crc_out)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- uart_byte_tx model and monitor ----------------
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_start) begin
        repeat (UART_CYC) @(posedge sys_clk);
        #1 tx_done = 1'b1;
        @(posedge sys_clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (tx_start) begin
      got_q.push_back(tx_data);
      start_cyc_q.push_back(cyc);
      start_cnt++;
    end
    if (tx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (err_len) err_cnt++;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [15:0] ref_crc(input frame_vec_t v);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < v.len; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ v.data[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  function automatic frame_vec_t make_vec(input int len, input logic [127:0] bytes,
                                          input logic [15:0] crc, input bit full_gap,
                                          input bit chk_space);
    frame_vec_t v;
    v.len = len;
    for (int i = 0; i < 16; i++) v.data[i] = bytes[127 - 8*i -: 8];
    v.exp_crc   = crc;
    v.full_gap  = full_gap;
    v.chk_space = chk_space;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic write_byte(input int addr, input logic [7:0] data);
    @(posedge sys_clk); #1;
    buf_wr_en   = 1'b1;
    buf_wr_addr = addr[3:0];
    buf_wr_data = data;
    @(posedge sys_clk); #1;
    buf_wr_en = 1'b0;
  endtask

  task automatic start_frame(input int len);
    @(posedge sys_clk); #1;
    frame_len   = len[4:0];
    frame_start = 1'b1;
    fs_cyc      = cyc;
    @(posedge sys_clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk);
    reset_n = 1'b0;
    #1;
    check("reset_crc", crc_out, 16'hFFFF);
    check("reset_busy", busy, 0);
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin
      @(negedge sys_clk);
      t++;
    end
    if (done_cnt < target) timeout(name);
  endtask

  task automatic wait_fd(input string name, input int target, input int budget);
    int t = 0;
    while (fd_cnt < target && t < budget) begin
      @(negedge sys_clk);
      t++;
    end
    if (fd_cnt < target) timeout(name);
  endtask

  // Loads, sends and checks one frame; leaves the DUT in its inter-frame gap.
  task automatic send_frame(input string name, input frame_vec_t v);
    int n, base_done;
    logic [7:0] e, g;
    n = v.len + CRC_BYTES;
    for (int i = 0; i < v.len; i++) write_byte(i, v.data[i]);
    got_q.delete();
    start_cyc_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.len; i++) exp_q.push_back(v.data[i]);
    if (CRC_BYTES == 2) begin
      exp_q.push_back(v.exp_crc[7:0]);
      exp_q.push_back(v.exp_crc[15:8]);
    end
    base_done = done_cnt;
    start_frame(v.len);
    @(negedge sys_clk);
    check($sformatf("%s busy_rise", name), busy, 1);
    wait_done($sformatf("%s bytes", name), base_done + n, n * (UART_CYC + 4) + 20);
    @(negedge sys_clk);
    check($sformatf("%s crc_out", name), crc_out, v.exp_crc);
    check($sformatf("%s start_latency", name), start_cyc_q[0] - fs_cyc, 2);
    if (v.chk_space) begin
      for (int i = 1; i < start_cyc_q.size(); i++)
        check($sformatf("%s spacing %0d", name, i), start_cyc_q[i] - start_cyc_q[i-1], UART_CYC + 2);
    end
    check($sformatf("%s byte_count", name), got_q.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check($sformatf("%s byte %0d", name, i), g, e);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int base_start, base_err, base_fd, t, k;
    reset_n = 1'b0; buf_wr_en = 1'b0; buf_wr_addr = '0; buf_wr_data = '0;
    frame_len = '0; frame_start = 1'b0;

    vecs[0] = make_vec(6, {48'h010300010001, 80'h0}, 16'hCAD5, 1'b1, 1'b0);
    vecs[1] = make_vec(8, {64'h01060002000_5E809, 64'h0}, 16'h0000, 1'b0, 1'b0);
    vecs[2] = make_vec(16, 128'h000102030405060708090A0B0C0D0E0F, 16'h0000, 1'b0, 1'b1);
    vecs[2].exp_crc = ref_crc(vecs[2]);
    vb = make_vec(6, {48'h010400010004, 80'h0}, 16'h09A0, 1'b0, 1'b0);
    vc = make_vec(6, {48'h010600010003, 80'h0}, 16'h0B98, 1'b0, 1'b0);

    // reset values
    repeat (3) @(negedge sys_clk);
    check("rst busy", busy, 0);
    check("rst frame_done", frame_done, 0);
    check("rst err_len", err_len, 0);
    check("rst tx_start", tx_start, 0);
    check("rst tx_data", tx_data, 8'h00);
    check("rst crc_out", crc_out, 16'hFFFF);
    reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // illegal lengths
    base_start = start_cnt; base_err = err_cnt;
    start_frame(0);
    @(negedge sys_clk);
    check("len0 err_len", err_len, 1);
    check("len0 busy", busy, 0);
    @(negedge sys_clk);
    check("len0 err_len width", err_len, 0);
    start_frame(17);
    @(negedge sys_clk);
    check("len17 err_len", err_len, 1);
    repeat (10) @(negedge sys_clk);
    check("err pulses", err_cnt - base_err, 2);
    check("err no tx_start", start_cnt - base_start, 0);
    check("err busy", busy, 0);

    // frame table
    for (int i = 0; i < 3; i++) begin
      base_fd = fd_cnt;
      send_frame($sformatf("vec%0d", i), vecs[i]);
      if (vecs[i].full_gap) begin
        wait_fd($sformatf("vec%0d frame_done", i), base_fd + 1, GAP_EXP + 200);
        check($sformatf("vec%0d gap_len", i), fd_cyc - last_done_cyc, GAP_EXP);
        @(negedge sys_clk);
        check($sformatf("vec%0d busy_fall", i), busy, 0);
        check($sformatf("vec%0d done_width", i), frame_done, 0);
      end else begin
        pulse_reset();
      end
    end

    // back-to-back frames; starts during the gap and on the frame_done cycle are ignored
    send_frame("frameB", vb);
    repeat (100) @(negedge sys_clk);
    base_start = start_cnt; base_err = err_cnt;
    start_frame(6);
    repeat (10) @(negedge sys_clk);
    check("gap start ignored", start_cnt - base_start, 0);
    check("gap start no err", err_cnt - base_err, 0);
    check("gap busy", busy, 1);
    t = 0;
    while (frame_done !== 1'b1 && t < GAP_EXP + 200) begin
      @(negedge sys_clk);
      t++;
    end
    if (frame_done !== 1'b1) timeout("frameB frame_done");
    else begin
      check("busy at frame_done", busy, 1);
      frame_len = 5'd6;
      frame_start = 1'b1;
      @(posedge sys_clk); #1;
      frame_start = 1'b0;
      @(negedge sys_clk);
      check("done-cycle start busy", busy, 0);
      check("done-cycle start err", err_len, 0);
      repeat (10) @(negedge sys_clk);
      check("done-cycle start ignored", start_cnt - base_start, 0);
    end
    send_frame("frameC", vc);
    pulse_reset();

    // buffer write while busy, then reset during byte 3
    got_q.delete();
    start_frame(6);
    t = 0; k = 0;
    while (k < 4 && t < 500) begin
      @(negedge sys_clk);
      t++;
      if (tx_start) begin
        k++;
        if (k == 1) write_byte(2, 8'hEE);
      end
    end
    if (k < 4) timeout("midreset byte3");
    reset_n = 1'b0;
    #1;
    check("midreset tx_start", tx_start, 0);
    check("midreset busy", busy, 0);
    check("midreset crc_out", crc_out, 16'hFFFF);
    check("busy write ignored", got_q[2], 8'h00);
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    base_start = start_cnt;
    repeat (UART_CYC + 10) @(negedge sys_clk);
    check("post reset idle tx", start_cnt - base_start, 0);
    check("post reset busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
